// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full adder over WIDTH cycles
//
// Purpose:
//   Adds two WIDTH-bit operands LSB first through a single 1-bit full adder.
//   A start/busy/done handshake lets a requester share the adder.
//   Optional subtract support is compiled in with `define SERIAL_SUB_EN.
//
// Parameters:
//   WIDTH  operand/result width, legal range 2..32 (default 8)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request an operation; sampled only in IDLE
//   a, b   in   operands, latched on the accepted start
//   sub    in   1 = a-b (only with SERIAL_SUB_EN), latched on start
//   busy   out  high while the adder is running
//   done   out  one-cycle pulse when sum/cout are valid
//   sum    out  result, stable from done until one cycle after the next start
//   cout   out  carry out of the MSB (subtract: 1 = no borrow)

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

`ifndef SERIAL_SUB_EN
    // Port kept for a stable interface; add-only build has no use for it.
    logic unused_sub;
    assign unused_sub = sub;
`endif

    fulladder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // The sum output register doubles as the result shift register:
    // each RUN cycle shifts the new bit in at the MSB, so after WIDTH
    // cycles bit 0 holds the first (LSB) result bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= a;
`ifdef SERIAL_SUB_EN
                        // a - b = a + ~b + 1: invert b and preload the carry.
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
`else
                        op_b  <= b;
                        carry <= 1'b0;
`endif
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= fa_cout;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    cnt   <= cnt + 1'b1;
                    // Compare before increment, so cnt never needs to wrap.
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl

module tb_serial_add_ctrl;
    localparam int W = 8;

`ifdef SERIAL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vs;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on WIDTH+1 bits.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        if (s && SUB_EN) r = {1'b0, x} + {1'b0, ~y} + 1;
        else             r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    // Issues one op (start driven in cycle T) and checks busy/done timing.
    // Returns at the negedge of cycle T+W+3.
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xs, output logic [W-1:0] rs, output logic rc);
        int busy_cnt;
        int done_cnt;
        int done_cyc;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        rs = '0;
        rc = 1'b0;
        @(negedge clk);
        a = xa; b = xb; sub = xs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= W + 3; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    rs = sum;
                    rc = cout;
                end
            end
        end
        check({tag, "_done_latency"}, done_cyc, W + 1);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, W);
        check({tag, "_sum_stable"}, sum, rs);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        logic [W:0]   ref_r;
        int           cnt_done;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
`ifdef SERIAL_SUB_EN
        tbl[6] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1};
        tbl[7] = '{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
`else
        tbl[6] = '{8'h10, 8'h01, 1'b1, 8'h11, 1'b0};
        tbl[7] = '{8'h01, 8'h02, 1'b1, 8'h03, 1'b0};
`endif

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].va, tbl[i].vb, tbl[i].vs, rs, rc);
            check($sformatf("tbl%0d_sum", i), rs, tbl[i].es);
            check($sformatf("tbl%0d_cout", i), rc, tbl[i].ec);
        end

        // Re-pulse while busy is ignored; start held through DONE re-triggers.
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; sub = 1'b0; start = 1'b1;     // T
        @(negedge clk); start = 1'b0;                        // T+1
        @(negedge clk);                                      // T+2
        @(negedge clk); a = 8'h11; start = 1'b1;             // T+3
        @(negedge clk); start = 1'b0;                        // T+4
        repeat (5) @(negedge clk);                           // T+9
        check("repulse_done", done, 1);
        check("repulse_sum", sum, 8'h96);
        check("repulse_cout", cout, 0);
        a = 8'h22; b = 8'h33; start = 1'b1;                  // held through DONE
        @(negedge clk);                                      // T+10
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
        check("hold_sum_kept", sum, 8'h96);
        @(negedge clk);                                      // T+11
        start = 1'b0;
        check("hold_accept_busy", busy, 1);
        repeat (7) @(negedge clk);                           // T+18
        check("hold_t18_done", done, 0);
        @(negedge clk);                                      // T+19
        check("hold_t19_done", done, 1);
        check("hold_sum", sum, 8'h55);
        check("hold_cout", cout, 0);

        // Reset mid-RUN.
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;                  // T
        @(negedge clk); start = 1'b0;                        // T+1
        repeat (3) @(negedge clk);                           // T+4
        rst = 1'b1;
        @(negedge clk);                                      // T+5
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        cnt_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) cnt_done++;
        end
        check("midrst_no_activity", cnt_done, 0);
        run_op("post_rst", 8'h5A, 8'h3C, 1'b0, rs, rc);
        check("post_rst_sum", rs, 8'h96);
        check("post_rst_cout", rc, 0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rsb;
            ra  = W'($urandom);
            rb  = W'($urandom);
            rsb = 1'($urandom);
            ref_r = model(ra, rb, rsb);
            run_op($sformatf("rnd%0d", i), ra, rb, rsb, rs, rc);
            check($sformatf("rnd%0d_result", i), {23'd0, rc, rs}, {23'd0, ref_r});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
